// File: rtl/vector_control_sequencer_pkg.sv
// Control-word layout, instruction classes, ALU op codes and the
// combinational {type, func} -> control-word decode map.
package vec_ctrl_pkg;

  typedef struct packed {
    logic       brinco;
    logic       equal;
    logic       greater_equal;
    logic       less_equal;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       enable_read;
    logic       enable_write;
    logic       write_data_src;
    logic       flag_rd_src;
    logic       alu_data;
    logic       reg_write_s;
    logic       reg_write_v;
    logic       alu_src;
    logic [2:0] alu_op_s;
    logic [2:0] alu_op_v;
    logic [1:0] imm_src;
    logic       reg_src1;
    logic       reg_src2;
  } ctrl_word_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_MEM, CLS_VMEM, CLS_BRANCH, CLS_VEC, CLS_ILLEGAL
  } instr_class_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_DIV   = 3'd3;
  localparam logic [2:0] ALU_UNION = 3'd4;

  typedef struct packed {
    instr_class_e cls;
    ctrl_word_t   word;
    logic         illegal;
  } decode_t;

  function automatic decode_t decode(input logic [1:0] itype, input logic [4:0] func);
    decode_t d;
    logic    bad;
    d   = '0;
    bad = 1'b0;
    case (itype)
      2'b00: begin
        d.cls = func[4] ? CLS_VMEM : CLS_MEM;
        case (func[4:3])
          2'b00: begin
            d.word.mem_read = 1'b1; d.word.mem_to_reg = 1'b1; d.word.reg_write_s = 1'b1;
            d.word.alu_src  = 1'b1; d.word.imm_src    = 2'b01;
          end
          2'b01: begin
            d.word.mem_write = 1'b1; d.word.alu_src = 1'b1; d.word.imm_src = 2'b01;
          end
          2'b10: begin
            d.word.enable_read = 1'b1; d.word.mem_to_reg = 1'b1; d.word.reg_write_v = 1'b1;
          end
          default: begin
            d.word.enable_write = 1'b1; d.word.write_data_src = 1'b1;
          end
        endcase
      end
      2'b01: begin
        if (!func[4]) begin
          // codes 0-4 are register ALU ops, 5 is the architectural nop
          if (!func[3] && func[2:0] <= ALU_UNION) begin
            d.cls = CLS_ALU; d.word.alu_data = 1'b1; d.word.reg_write_s = 1'b1;
            d.word.alu_op_s = func[2:0];
          end else if (!func[3] && func[2:0] == 3'd5) begin
            d.cls = CLS_NOP;
          end else begin
            bad = 1'b1;
          end
        end else if (func[3:1] <= ALU_UNION) begin
          d.cls = CLS_ALU; d.word.alu_data = 1'b1; d.word.reg_write_s = 1'b1;
          d.word.alu_src = 1'b1; d.word.imm_src = 2'b10; d.word.alu_op_s = func[3:1];
        end else begin
          bad = 1'b1;
        end
      end
      2'b10: begin
        d.cls = CLS_BRANCH;
        d.word.alu_op_s = ALU_SUB;
        case (func[4:3])
          2'b00:   d.word.brinco        = 1'b1;
          2'b01:   d.word.less_equal    = 1'b1;
          2'b10:   d.word.equal         = 1'b1;
          default: d.word.greater_equal = 1'b1;
        endcase
      end
      default: begin
        if (func[4:3] != 2'b11 && func[2:0] <= ALU_UNION) begin
          d.cls = CLS_VEC; d.word.reg_write_v = 1'b1; d.word.alu_op_v = func[2:0];
          if (func[4:3] == 2'b01) d.word.reg_src2 = 1'b1;
          if (func[4:3] == 2'b10) begin d.word.alu_src = 1'b1; d.word.imm_src = 2'b11; end
        end else begin
          bad = 1'b1;
        end
      end
    endcase
    if (bad) begin
      d.word    = '0;
      d.cls     = CLS_ILLEGAL;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/vector_control_sequencer_if.sv
// Issue-side and memory-beat signals of the sequencer; the DUT takes the slave view.
interface vector_control_sequencer_if import vec_ctrl_pkg::*; #(
  parameter int VLEN = 4
);
  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;

  logic          instr_valid_i;
  logic          instr_ready_o;
  logic [1:0]    instruction_type_i;
  logic [4:0]    func_i;
  logic          flush_i;
  logic          ctrl_valid_o;
  ctrl_word_t    ctrl_o;
  logic          illegal_o;
  logic          mem_req_o;
  logic          mem_ack_i;
  logic [IW-1:0] elem_idx_o;
  logic          last_beat_o;

  modport slave (
    input  instr_valid_i, instruction_type_i, func_i, flush_i, mem_ack_i,
    output instr_ready_o, ctrl_valid_o, ctrl_o, illegal_o, mem_req_o, elem_idx_o, last_beat_o
  );

  modport master (
    output instr_valid_i, instruction_type_i, func_i, flush_i, mem_ack_i,
    input  instr_ready_o, ctrl_valid_o, ctrl_o, illegal_o, mem_req_o, elem_idx_o, last_beat_o
  );
endinterface

// File: rtl/vector_control_sequencer_decode.sv
// Combinational wrapper around the package decode map.
module vec_ctrl_decode import vec_ctrl_pkg::*; (
  input  logic [1:0] instruction_type,
  input  logic [4:0] func,
  output decode_t    dec
);
  assign dec = decode(instruction_type, func);
endmodule

// File: rtl/vector_control_sequencer.sv
// Registered decoder plus vector memory beat sequencer (IDLE / ISSUE / VMEM).
module vector_control_sequencer import vec_ctrl_pkg::*; #(
  parameter int VLEN  = 4,
  parameter int LANES = 1
) (
  input logic                        clk,
  input logic                        rst_n,
  vector_control_sequencer_if.slave  bus
);
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (VLEN > 1) ? $clog2(VLEN) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] VMEM  = 2'd2;

  if (VLEN < 1 || (VLEN & (VLEN - 1)) != 0) begin : g_bad_vlen
    $error("VLEN must be a power of two >= 1");
  end
  if (LANES < 1 || (LANES & (LANES - 1)) != 0 || (VLEN % LANES) != 0) begin : g_bad_lanes
    $error("LANES must be a power of two dividing VLEN");
  end

  logic [1:0]    state;
  logic [BW-1:0] beat;
  ctrl_word_t    ctrl_q;
  logic          illegal_q;
  decode_t       dec;
  logic          ready, accept, last;

  vec_ctrl_decode u_dec (
    .instruction_type (bus.instruction_type_i),
    .func             (bus.func_i),
    .dec              (dec)
  );

  assign ready  = (state == IDLE || state == ISSUE) && !bus.flush_i && rst_n;
  assign accept = bus.instr_valid_i && ready;
  assign last   = (beat == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      state     <= (dec.cls == CLS_VMEM) ? VMEM : ISSUE;
      beat      <= '0;
      ctrl_q    <= dec.word;
      illegal_q <= dec.illegal;
    end else if (state == VMEM) begin
      // flush is deliberately not looked at here: a started transfer always completes
      if (bus.mem_ack_i) begin
        if (last) begin
          state  <= IDLE;
          beat   <= '0;
          ctrl_q <= '0;
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end else begin
      state     <= IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end
  end

  assign bus.instr_ready_o = ready;
  assign bus.ctrl_valid_o  = (state == VMEM) || (state == ISSUE && !bus.flush_i);
  assign bus.ctrl_o        = ctrl_q;
  assign bus.illegal_o     = (state == ISSUE) && illegal_q && !bus.flush_i;
  assign bus.mem_req_o     = (state == VMEM);
  assign bus.elem_idx_o    = IW'(int'(beat) * LANES);
  assign bus.last_beat_o   = (state == VMEM) && last;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Directed bench: three sequencer instances covering VLEN/LANES = 4/1, 8/2 and 2/2.
module tb_vector_control_sequencer;
  import vec_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  vector_control_sequencer_if #(.VLEN(4)) b0 ();
  vector_control_sequencer_if #(.VLEN(8)) b1 ();
  vector_control_sequencer_if #(.VLEN(2)) b2 ();

  vector_control_sequencer #(.VLEN(4), .LANES(1)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  vector_control_sequencer #(.VLEN(8), .LANES(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  vector_control_sequencer #(.VLEN(2), .LANES(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (b0.instr_ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", b0.instr_ready_o); else n_pass++;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o !== ctrl_word_t'(0)) $display("FAIL rst_ctrl: got %h want 0", b0.ctrl_o); else n_pass++;
    n_total++; if (b0.mem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", b0.mem_req_o); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (b0.instr_ready_o !== 1'b1) $display("FAIL rst_rel_ready: got %b want 1", b0.instr_ready_o); else n_pass++;
    b0.instr_valid_i = 1'b1; b0.instruction_type_i = 2'b00; b0.func_i = 5'b10000;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b0; b0.mem_ack_i = 1'b1;
    #1;
    n_total++; if (b0.mem_req_o !== 1'b1) $display("FAIL rst_vm_req: got %b want 1", b0.mem_req_o); else n_pass++;
    n_total++; if (b0.elem_idx_o !== 2'd0) $display("FAIL rst_vm_idx0: got %0d want 0", b0.elem_idx_o); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (b0.elem_idx_o !== 2'd1) $display("FAIL rst_vm_idx1: got %0d want 1", b0.elem_idx_o); else n_pass++;
    @(posedge clk); #1;
    b0.mem_ack_i = 1'b0;
    #1;
    n_total++; if (b0.elem_idx_o !== 2'd2) $display("FAIL rst_vm_idx2: got %0d want 2", b0.elem_idx_o); else n_pass++;
    n_total++; if (b0.ctrl_o.reg_write_v !== 1'b1) $display("FAIL rst_vm_rwv: got %b want 1", b0.ctrl_o.reg_write_v); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (b0.mem_req_o !== 1'b0) $display("FAIL rst_mid_req: got %b want 0", b0.mem_req_o); else n_pass++;
    n_total++; if (b0.elem_idx_o !== 2'd0) $display("FAIL rst_mid_idx: got %0d want 0", b0.elem_idx_o); else n_pass++;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o !== ctrl_word_t'(0)) $display("FAIL rst_mid_ctrl: got %h want 0", b0.ctrl_o); else n_pass++;
    n_total++; if (b0.instr_ready_o !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", b0.instr_ready_o); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_total++; if (b0.instr_ready_o !== 1'b1) $display("FAIL rst_after_ready: got %b want 1", b0.instr_ready_o); else n_pass++;
    n_total++; if (b0.mem_req_o !== 1'b0) $display("FAIL rst_after_req: got %b want 0", b0.mem_req_o); else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b1; b0.instruction_type_i = 2'b01; b0.func_i = 5'b00000;
    @(posedge clk); #1;
    b0.func_i = 5'b00001;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b1) $display("FAIL b2b_v0: got %b want 1", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o.alu_op_s !== 3'b000) $display("FAIL b2b_op0: got %b want 000", b0.ctrl_o.alu_op_s); else n_pass++;
    n_total++; if (b0.ctrl_o.reg_write_s !== 1'b1) $display("FAIL b2b_rws0: got %b want 1", b0.ctrl_o.reg_write_s); else n_pass++;
    n_total++; if (b0.instr_ready_o !== 1'b1) $display("FAIL b2b_ready: got %b want 1", b0.instr_ready_o); else n_pass++;
    @(posedge clk); #1;
    b0.func_i = 5'b10100;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b1) $display("FAIL b2b_v1: got %b want 1", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o.alu_op_s !== 3'b001) $display("FAIL b2b_op1: got %b want 001", b0.ctrl_o.alu_op_s); else n_pass++;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b0;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b1) $display("FAIL b2b_v2: got %b want 1", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o.alu_op_s !== 3'b010) $display("FAIL b2b_op2: got %b want 010", b0.ctrl_o.alu_op_s); else n_pass++;
    n_total++; if (b0.ctrl_o.alu_src !== 1'b1) $display("FAIL b2b_src2: got %b want 1", b0.ctrl_o.alu_src); else n_pass++;
    n_total++; if (b0.ctrl_o.imm_src !== 2'b10) $display("FAIL b2b_imm2: got %b want 10", b0.ctrl_o.imm_src); else n_pass++;
    @(posedge clk); #2;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL b2b_idle: got %b want 0", b0.ctrl_valid_o); else n_pass++;
  endtask

  task automatic test_vload;
    int ack_pat [5];
    int idx_exp [5];
    ack_pat = '{1, 0, 1, 1, 1};
    idx_exp = '{0, 2, 2, 4, 6};
    @(posedge clk); #1;
    b1.instr_valid_i = 1'b1; b1.instruction_type_i = 2'b00; b1.func_i = 5'b10000;
    @(posedge clk); #1;
    b1.instr_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b1.mem_ack_i = ack_pat[i][0];
      #1;
      n_total++; if (int'(b1.elem_idx_o) != idx_exp[i]) $display("FAIL vld_idx%0d: got %0d want %0d", i, b1.elem_idx_o, idx_exp[i]); else n_pass++;
      n_total++; if (b1.last_beat_o !== (i == 4)) $display("FAIL vld_last%0d: got %b want %b", i, b1.last_beat_o, (i == 4)); else n_pass++;
      n_total++; if (b1.instr_ready_o !== 1'b0) $display("FAIL vld_ready%0d: got %b want 0", i, b1.instr_ready_o); else n_pass++;
      n_total++; if (b1.mem_req_o !== 1'b1) $display("FAIL vld_req%0d: got %b want 1", i, b1.mem_req_o); else n_pass++;
      @(posedge clk); #1;
    end
    b1.mem_ack_i = 1'b0;
    #1;
    n_total++; if (b1.mem_req_o !== 1'b0) $display("FAIL vld_done_req: got %b want 0", b1.mem_req_o); else n_pass++;
    n_total++; if (b1.instr_ready_o !== 1'b1) $display("FAIL vld_done_ready: got %b want 1", b1.instr_ready_o); else n_pass++;
  endtask

  task automatic test_vstore_single;
    @(posedge clk); #1;
    b2.instr_valid_i = 1'b1; b2.instruction_type_i = 2'b00; b2.func_i = 5'b11000;
    @(posedge clk); #1;
    b2.instr_valid_i = 1'b0; b2.mem_ack_i = 1'b1;
    #1;
    n_total++; if (b2.mem_req_o !== 1'b1) $display("FAIL vst_req: got %b want 1", b2.mem_req_o); else n_pass++;
    n_total++; if (b2.last_beat_o !== 1'b1) $display("FAIL vst_last: got %b want 1", b2.last_beat_o); else n_pass++;
    n_total++; if (b2.ctrl_o.enable_write !== 1'b1) $display("FAIL vst_enw: got %b want 1", b2.ctrl_o.enable_write); else n_pass++;
    n_total++; if (b2.ctrl_o.write_data_src !== 1'b1) $display("FAIL vst_wds: got %b want 1", b2.ctrl_o.write_data_src); else n_pass++;
    n_total++; if (b2.elem_idx_o !== 1'b0) $display("FAIL vst_idx: got %0d want 0", b2.elem_idx_o); else n_pass++;
    @(posedge clk); #1;
    b2.mem_ack_i = 1'b0;
    #1;
    n_total++; if (b2.mem_req_o !== 1'b0) $display("FAIL vst_done_req: got %b want 0", b2.mem_req_o); else n_pass++;
    n_total++; if (b2.instr_ready_o !== 1'b1) $display("FAIL vst_done_ready: got %b want 1", b2.instr_ready_o); else n_pass++;
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    b0.flush_i = 1'b1; b0.instr_valid_i = 1'b1; b0.instruction_type_i = 2'b01; b0.func_i = 5'b00000;
    #1;
    n_total++; if (b0.instr_ready_o !== 1'b0) $display("FAIL fl_idle_ready: got %b want 0", b0.instr_ready_o); else n_pass++;
    @(posedge clk); #1;
    b0.flush_i = 1'b0; b0.instr_valid_i = 1'b0;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL fl_idle_noacc: got %b want 0", b0.ctrl_valid_o); else n_pass++;
    b0.instr_valid_i = 1'b1; b0.instruction_type_i = 2'b10; b0.func_i = 5'b11000;
    @(posedge clk); #1;
    b0.func_i = 5'b10000;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b1) $display("FAIL fl_geq_valid: got %b want 1", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o.greater_equal !== 1'b1) $display("FAIL fl_geq_bit: got %b want 1", b0.ctrl_o.greater_equal); else n_pass++;
    n_total++; if (b0.ctrl_o.alu_op_s !== 3'b001) $display("FAIL fl_geq_op: got %b want 001", b0.ctrl_o.alu_op_s); else n_pass++;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b0; b0.flush_i = 1'b1;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL fl_issue_valid: got %b want 0", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.illegal_o !== 1'b0) $display("FAIL fl_issue_ill: got %b want 0", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
    b0.flush_i = 1'b0;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b0) $display("FAIL fl_issue_idle: got %b want 0", b0.ctrl_valid_o); else n_pass++;
    // flush held high across a whole vector load on the 8/2 instance
    b1.instr_valid_i = 1'b1; b1.instruction_type_i = 2'b00; b1.func_i = 5'b10000;
    @(posedge clk); #1;
    b1.instr_valid_i = 1'b0; b1.flush_i = 1'b1; b1.mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (int'(b1.elem_idx_o) != 2 * i) $display("FAIL fl_vm_idx%0d: got %0d want %0d", i, b1.elem_idx_o, 2 * i); else n_pass++;
      n_total++; if (b1.mem_req_o !== 1'b1) $display("FAIL fl_vm_req%0d: got %b want 1", i, b1.mem_req_o); else n_pass++;
      @(posedge clk); #1;
    end
    b1.flush_i = 1'b0; b1.mem_ack_i = 1'b0;
    #1;
    n_total++; if (b1.mem_req_o !== 1'b0) $display("FAIL fl_vm_done: got %b want 0", b1.mem_req_o); else n_pass++;
  endtask

  task automatic test_illegal;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b1; b0.instruction_type_i = 2'b01; b0.func_i = 5'b00110;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b0;
    #1;
    n_total++; if (b0.illegal_o !== 1'b1) $display("FAIL ill_pulse: got %b want 1", b0.illegal_o); else n_pass++;
    n_total++; if (b0.ctrl_o !== ctrl_word_t'(0)) $display("FAIL ill_ctrl: got %h want 0", b0.ctrl_o); else n_pass++;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b1; b0.func_i = 5'b00101;
    #1;
    n_total++; if (b0.illegal_o !== 1'b0) $display("FAIL ill_pulse_end: got %b want 0", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
    b0.instruction_type_i = 2'b11; b0.func_i = 5'b11000;
    #1;
    n_total++; if (b0.ctrl_valid_o !== 1'b1) $display("FAIL nop_valid: got %b want 1", b0.ctrl_valid_o); else n_pass++;
    n_total++; if (b0.ctrl_o !== ctrl_word_t'(0)) $display("FAIL nop_ctrl: got %h want 0", b0.ctrl_o); else n_pass++;
    n_total++; if (b0.illegal_o !== 1'b0) $display("FAIL nop_ill: got %b want 0", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
    b0.func_i = 5'b00010;
    #1;
    n_total++; if (b0.illegal_o !== 1'b1) $display("FAIL ill_vec: got %b want 1", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
    b0.instruction_type_i = 2'b01; b0.func_i = 5'b11010;
    #1;
    n_total++; if (b0.ctrl_o.alu_op_v !== 3'b010) $display("FAIL vec_op: got %b want 010", b0.ctrl_o.alu_op_v); else n_pass++;
    n_total++; if (b0.ctrl_o.reg_write_v !== 1'b1) $display("FAIL vec_rwv: got %b want 1", b0.ctrl_o.reg_write_v); else n_pass++;
    n_total++; if (b0.illegal_o !== 1'b0) $display("FAIL vec_ill: got %b want 0", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
    b0.instr_valid_i = 1'b0;
    #1;
    n_total++; if (b0.illegal_o !== 1'b1) $display("FAIL ill_immop: got %b want 1", b0.illegal_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    b0.instr_valid_i = 1'b0; b0.instruction_type_i = 2'b00; b0.func_i = 5'd0; b0.flush_i = 1'b0; b0.mem_ack_i = 1'b0;
    b1.instr_valid_i = 1'b0; b1.instruction_type_i = 2'b00; b1.func_i = 5'd0; b1.flush_i = 1'b0; b1.mem_ack_i = 1'b0;
    b2.instr_valid_i = 1'b0; b2.instruction_type_i = 2'b00; b2.func_i = 5'd0; b2.flush_i = 1'b0; b2.mem_ack_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_vload();
    test_vstore_single();
    test_flush();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vector_control_sequencer.md
# vector_control_sequencer

Registered, parametrised instruction decoder and multi-beat sequencer that sits between fetch/issue and the execute/memory stages of the scalar+vector core. It decodes each accepted `{instruction_type, func}` into a control word one cycle later. Vector loads and stores are expanded internally into `VLEN/LANES` memory beats under a req/ack handshake, so software no longer encodes explicit stall-read/stall-write instructions. An illegal-encoding flag is raised for any undefined opcode.

## Interface
Parameters:
- `VLEN`, 4: elements per vector register; a power of two, ≥ 1.
- `LANES`, 1: elements moved per memory beat; a power of two that divides `VLEN`.
- `BEATS`, `VLEN/LANES` (derived, localparam): beats per vector memory instruction.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr_valid_i`  in  1: instruction offered.
- `instr_ready_o`  out  1: instruction accepted when valid & ready at a rising edge.
- `instruction_type_i`  in  2: 00 mem, 01 data, 10 control, 11 vector.
- `func_i`  in  5: function field.
- `flush_i`  in  1: branch-taken kill.
- `ctrl_valid_o`  out  1: `ctrl_o` is valid this cycle.
- `ctrl_o`  out  `$bits(ctrl_word_t)`: packed control word.
- `illegal_o`  out  1: one-cycle pulse with an all-zero `ctrl_o`.
- `mem_req_o`  out  1: vector beat request.
- `mem_ack_i`  in  1: beat accepted.
- `elem_idx_o`  out  `$clog2(VLEN)` (min 1): first element index of the current beat.
- `last_beat_o`  out  1: current beat is beat `BEATS-1`.

## Operation
- States are IDLE, ISSUE and VMEM.
- `instr_ready_o` = (state is IDLE or ISSUE) & !`flush_i` & `rst_n`.
- On accept, the word is decoded from the package map and registered:
  - An ordinary instruction goes to ISSUE.
  - A vector load or store (type 00, `func[4]`=1) goes to VMEM with beat=0.
- ISSUE holds `ctrl_valid_o`=1 for exactly one cycle. On a new accept it stays in ISSUE or goes to VMEM as above; otherwise it returns to IDLE.
- VMEM:
  - `ctrl_valid_o`=1, `mem_req_o`=1, `elem_idx_o`=beat·LANES.
  - `reg_write_v` (load) or `enable_write` (store) is asserted each beat.
  - On `mem_ack_i`, beat++.
  - Ack while on beat `BEATS-1` goes to IDLE.
  - With no ack, all outputs hold unchanged.
- Decode map (in package):
  - type 00: `func[4:3]` selects load / store / vload / vstore.
  - type 01: `func[4]`=0 gives add, sub, mul, div, union for codes 0–4, and nop for 5. `func[4]`=1 gives the immediate ops, with ALU op = `func[3:1]`.
  - type 10: `func[4:3]` selects brinco / leq / igual / geq, with `alu_op_s`=001.
  - type 11: vector-vector, vector-scalar and vector-immediate ops.
- Illegal encodings are type 01 codes 6–7, type 11 unused codes, and all other codes the map does not assign. They result in ISSUE with `illegal_o`=1 and `ctrl_o`=0.
- Nop results in ISSUE with `ctrl_valid_o`=1 and `ctrl_o`=0.
- No don't-care values are driven; every unused field is 0.
- `flush_i` in ISSUE: `ctrl_valid_o` and `illegal_o` are forced to 0 that cycle, and the next state is IDLE.
- `flush_i` in IDLE: blocks acceptance.
- `flush_i` in VMEM: ignored, because memory operations are committed once started.
- Flush together with `instr_valid_i`: the flush wins and nothing is accepted.

## Timing
- Decode latency is 1: accept at edge k gives `ctrl_o` valid during cycle k+1.
- Scalar throughput is 1 instruction per cycle.
- A vector memory operation occupies ≥ BEATS cycles. The earliest next accept is in the cycle after the last-beat ack edge; an accept cannot coincide with that ack cycle.
- `BEATS`=1 is a single VMEM cycle with `last_beat_o`=1.
- Reset (`rst_n` low, asynchronous): state IDLE, beat 0, `instr_ready_o`=0, and `ctrl_valid_o`, `ctrl_o`, `illegal_o`, `mem_req_o`, `elem_idx_o`, `last_beat_o` all 0.
- Reset mid-VMEM abandons the transfer immediately; the beat counter is cleared.
- After `rst_n` rises, `instr_ready_o`=1 in the first cycle.

## Structure
- Package `vec_ctrl_pkg` holds:
  - `ctrl_word_t`, a packed struct of: brinco, equal, greater_equal, less_equal, mem_to_reg, mem_read, mem_write, enable_read, enable_write, write_data_src, flag_rd_src, alu_data, reg_write_s, reg_write_v, alu_src, alu_op_s[2:0], alu_op_v[2:0], imm_src[1:0], reg_src1, reg_src2.
  - An `instr_class_e` enum.
  - ALU op constants.
  - A `decode()` function returning {class, word, illegal}.
- Sub-module `vec_ctrl_decode` is purely combinational and wraps `decode()`, so it can be unit-tested alone.
- The sequencer top owns the FSM, beat counter and output registers.
- Elaboration assertions check the `VLEN` and `LANES` constraints.

## Test plan
- Reset: assert `rst_n`=0 mid-VMEM with VLEN=4, LANES=1, beat 2 → all outputs 0 at once; after release, IDLE and `instr_ready_o`=1.
- Back-to-back scalar ops: type 01 func 00000, 00001, 10100 on three consecutive cycles → `ctrl_valid_o` for 3 consecutive cycles with `alu_op_s` 000, 001, 010; the last has `alu_src`=1 and `imm_src`=10.
- Vector load, VLEN=8, LANES=2: `mem_ack_i` pattern 1,0,1,1,1 → `elem_idx_o` 0,2,2,4,6; `last_beat_o` only with idx 6; `instr_ready_o` low throughout.
- Vector store, BEATS=1 → single VMEM cycle with `enable_write`=1, `write_data_src`=1, `last_beat_o`=1.
- Flush: `flush_i` with `instr_valid_i` in IDLE → no accept. Flush in ISSUE of a type 10 func 10xxx → no `ctrl_valid_o`. Flush during VMEM → ignored; beats complete.
- Illegal: type 01 func 00110 → `illegal_o` pulse, `ctrl_o`=0. Type 01 func 00101 → `ctrl_valid_o`=1, `ctrl_o`=0, no illegal.
